// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM encoding
// and the request legality/alignment check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Illegal size code, or an access not naturally aligned to its size.
  // Unsigned sizes only exist for loads, so a store with funct3[2] set is illegal.
  function automatic logic lsu_access_err(input logic we, input logic [2:0] funct3,
                                          input logic [1:0] off);
    logic illegal;
    logic misaligned;
    illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                 (funct3[2] && we);
    misaligned = (((funct3 == F3_H) || (funct3 == F3_HU)) && off[0]) ||
                 ((funct3 == F3_W) && (off != 2'b00));
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: merges store data into a read word and
// extracts/extends load data from a word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [15:0] wdata,
  input  logic [31:0] word,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    shifted   = word >> {byte_off, 3'b000};
    merged    = word;
    load_data = word;
    case (funct3)
      F3_B: begin
        merged[{byte_off, 3'b000} +: 8] = wdata[7:0];
        load_data = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_H: begin
        merged[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
        load_data = {{16{shifted[15]}}, shifted[15:0]};
      end
      F3_BU:   load_data = {24'b0, shifted[7:0]};
      F3_HU:   load_data = {16'b0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-addressed data memory with
// combinational read; sub-word stores are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH_LOG2 = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output lsu_state_e  dbg_state
);

  // Handshakes: a request transfers on a cycle where req_valid && req_ready
  // (ready only in IDLE); a response transfers where resp_valid && resp_ready,
  // and resp_rdata/resp_err stay constant while resp_valid waits for ready.

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_re_q, mem_re_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic        req_err;
  logic [31:0] merged;
  logic [31:0] load_data;

  assign req_err = lsu_access_err(req_we, req_funct3, req_addr[1:0]) ||
                   (|req_addr[31:DEPTH_LOG2+2]);

  lsu_align u_align (
    .funct3    (funct3_q),
    .byte_off  (off_q),
    .wdata     (wdata_q),
    .word      (mem_rdata),
    .merged    (merged),
    .load_data (load_data)
  );

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_re_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_wdata_d  = 32'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d         = req_we;
          funct3_d     = req_funct3;
          off_d        = req_addr[1:0];
          wdata_d      = req_wdata[15:0];
          resp_rdata_d = 32'b0;
          resp_err_d   = 1'b0;
          if (req_err) begin
            state_d    = ST_RESP;
            resp_err_d = 1'b1;
          end else if (req_we && (req_funct3 == F3_W)) begin
            state_d     = ST_WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = 32'(req_addr[DEPTH_LOG2+1:2]);
            mem_wdata_d = req_wdata;
          end else begin
            state_d    = ST_READ;
            mem_re_d   = 1'b1;
            mem_addr_d = 32'(req_addr[DEPTH_LOG2+1:2]);
          end
        end
      end
      ST_READ: begin
        if (we_q) begin
          state_d     = ST_WRITE;
          mem_we_d    = 1'b1;
          mem_wdata_d = merged;
        end else begin
          state_d      = ST_RESP;
          mem_addr_d   = 32'b0;
          resp_rdata_d = load_data;
        end
      end
      ST_WRITE: begin
        state_d    = ST_RESP;
        mem_addr_d = 32'b0;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_rdata_d = 32'b0;
          resp_err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Async reset also drops a pending mem_we, so an interrupted store never writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b0;
      off_q        <= 2'b0;
      wdata_q      <= 16'b0;
      mem_addr_q   <= 32'b0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= 32'b0;
      resp_rdata_q <= 32'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_re     = mem_re_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single transactions
// plus hand-written stall and mid-store reset sequences, with a memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  lsu_state_e  dbg_state;

  logic [31:0] mem [32];

  int checks = 0;
  int errors = 0;

  load_store_unit #(.DEPTH_LOG2(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .dbg_state  (dbg_state)
  );

  // clock / reset and memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[4:0]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[4:0]] <= mem_wdata;
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_re;
    int          exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input logic exp_err, input int exp_lat, input int exp_re,
                              input int exp_we, input logic [31:0] exp_wdata);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    v.exp_re = exp_re; v.exp_we = exp_we; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one request, waits (bounded) for resp_valid, and checks the
  // memory-side activity seen along the way. Leaves the DUT in RESP.
  task automatic run_txn(input int idx, input vec_t v);
    int lat, re_cnt, we_cnt;
    logic [31:0] wd_seen;
    logic [31:0] exp_idx;
    bit got;
    lat = 0; re_cnt = 0; we_cnt = 0; wd_seen = 32'b0; got = 1'b0;
    exp_idx = {2'b00, v.addr[31:2]};
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      chk($sformatf("v%0d re_we_excl", idx), {31'b0, mem_re & mem_we}, 32'b0);
      if (mem_re) begin
        re_cnt++;
        chk($sformatf("v%0d rd_addr", idx), mem_addr, exp_idx);
      end
      if (mem_we) begin
        we_cnt++;
        wd_seen = mem_wdata;
        chk($sformatf("v%0d wr_addr", idx), mem_addr, exp_idx);
      end
      if (resp_valid) got = 1'b1;
    end
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL v%0d timeout: no resp_valid after %0d cycles, required %0d", idx, lat, v.exp_lat);
    end else begin
      chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
      chk($sformatf("v%0d rdata", idx), resp_rdata, v.exp_rdata);
      chk($sformatf("v%0d err", idx), {31'b0, resp_err}, {31'b0, v.exp_err});
      chk($sformatf("v%0d re_cnt", idx), re_cnt, v.exp_re);
      chk($sformatf("v%0d we_cnt", idx), we_cnt, v.exp_we);
      chk($sformatf("v%0d req_ready_in_resp", idx), {31'b0, req_ready}, 32'b0);
      if (v.exp_we != 0) chk($sformatf("v%0d wdata", idx), wd_seen, v.exp_wdata);
    end
  endtask

  int  rst_we_cnt;
  bit  in_rst_window;
  always @(posedge clk) begin
    if (in_rst_window && mem_we) rst_we_cnt++;
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = i * 20;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'b0; req_wdata = 32'b0; resp_ready = 1'b1;
    rst_we_cnt = 0; in_rst_window = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst mem_re", {31'b0, mem_re}, 32'd0);
    chk("rst mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst state", {30'b0, dbg_state}, {30'b0, ST_IDLE});

    //              we    f3      addr          wdata         rdata         err  lat re we wdata
    vecs.push_back(mk(1'b0, F3_W,   32'h0000000C, 32'h0,        32'h0000003C, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1'b1, F3_B,   32'h0000000D, 32'h000000A5, 32'h0,        1'b0, 3, 1, 1, 32'h0000A53C));
    vecs.push_back(mk(1'b0, F3_B,   32'h0000000D, 32'h0,        32'hFFFFFFA5, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1'b0, F3_BU,  32'h0000000D, 32'h0,        32'h000000A5, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1'b0, F3_H,   32'h0000000C, 32'h0,        32'hFFFFA53C, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1'b0, F3_HU,  32'h0000000C, 32'h0,        32'h0000A53C, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1'b1, F3_H,   32'h00000012, 32'h00008001, 32'h0,        1'b0, 3, 1, 1, 32'h80010050));
    vecs.push_back(mk(1'b0, F3_H,   32'h00000012, 32'h0,        32'hFFFF8001, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1'b0, F3_HU,  32'h00000012, 32'h0,        32'h00008001, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1'b0, F3_W,   32'h00000010, 32'h0,        32'h80010050, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1'b0, F3_B,   32'h00000013, 32'h0,        32'hFFFFFF80, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1'b0, F3_BU,  32'h0000007F, 32'h0,        32'h00000000, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1'b0, F3_H,   32'h0000000F, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1'b0, F3_W,   32'h00000006, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1'b0, F3_W,   32'h00000080, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1'b0, F3_W,   32'hFFFFFF80, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1'b0, 3'b011, 32'h00000000, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1'b1, F3_BU,  32'h00000000, 32'h12345678, 32'h0,        1'b1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1'b1, F3_W,   32'h00000002, 32'h12345678, 32'h0,        1'b1, 1, 0, 0, 32'h0));

    foreach (vecs[i]) run_txn(i, vecs[i]);

    // SW with the response held back for 5 cycles
    @(negedge clk);
    resp_ready = 1'b0;
    run_txn(100, mk(1'b1, F3_W, 32'h0000007C, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1, 32'hDEADBEEF));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d resp_valid", c), {31'b0, resp_valid}, 32'd1);
      chk($sformatf("stall%0d rdata", c), resp_rdata, 32'd0);
      chk($sformatf("stall%0d err", c), {31'b0, resp_err}, 32'd0);
      chk($sformatf("stall%0d req_ready", c), {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall release resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("stall release req_ready", {31'b0, req_ready}, 32'd1);
    chk("stall mem word31", mem[31], 32'hDEADBEEF);
    run_txn(101, mk(1'b0, F3_W, 32'h0000007C, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0, 32'h0));

    // SB interrupted by reset while in WRITE
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B;
    req_addr = 32'h00000000; req_wdata = 32'h00000011;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rmw state read", {30'b0, dbg_state}, {30'b0, ST_READ});
    @(negedge clk);
    chk("rmw state write", {30'b0, dbg_state}, {30'b0, ST_WRITE});
    chk("rmw mem_we before reset", {31'b0, mem_we}, 32'd1);
    in_rst_window = 1'b1;
    reset = 1'b1;
    #1;
    chk("rmw mem_we in reset", {31'b0, mem_we}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post-rst state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    chk("post-rst resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("post-rst req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    in_rst_window = 1'b0;
    chk("post-rst no write", rst_we_cnt, 32'd0);
    chk("post-rst mem word0", mem[0], 32'd0);
    run_txn(102, mk(1'b0, F3_W, 32'h00000000, 32'h0, 32'h00000000, 1'b0, 2, 1, 0, 32'h0));

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
